vgaram_arbiter: RTL and testbench
=================================

VGARAM_ARBITER -- requirements
Module: vgaram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_vga_addr  input  ADDR_W  VGA fetch address.
REQ-006 SHALL have port i_vga_cs  input  1  VGA accesses RAM this cycle.
REQ-007 SHALL have port i_vga_access  input  1  VGA will access RAM next cycle.
REQ-008 SHALL have port o_vga_dat  output  DATA_W  RAM read data to VGA.
REQ-009 SHALL have port i_cpu_addr  input  ADDR_W  CPU address.
REQ-010 SHALL have port i_cpu_dat  input  DATA_W  CPU write data.
REQ-011 SHALL have port i_cpu_cs  input  1  CPU request, held high until ack.
REQ-012 SHALL have port i_cpu_we  input  1  CPU write (1) / read (0).
REQ-013 SHALL have port o_cpu_dat  output  DATA_W  registered CPU read data.
REQ-014 SHALL have port o_cpu_ack  output  1  one-cycle completion pulse.
REQ-015 SHALL have ports o_ram_addr (output, ADDR_W), o_ram_dat (output, DATA_W), o_ram_cs (output, 1), o_ram_we (output, 1), i_ram_dat (input, DATA_W); the RAM is synchronous, read data valid the cycle after o_ram_cs.

Function
REQ-016 VGA SHALL have absolute priority; when i_vga_cs=1, o_ram_addr=i_vga_addr, o_ram_cs=1, o_ram_we=0, combinationally.
REQ-017 o_vga_dat SHALL equal i_ram_dat combinationally at all times.
REQ-018 FSM states SHALL be IDLE, GRANT, DONE.
REQ-019 IDLE->GRANT SHALL occur when i_cpu_cs=1 and i_vga_access=0 in the same cycle; otherwise the FSM stays in IDLE.
REQ-020 In GRANT with i_vga_cs=0, the RAM SHALL be driven with i_cpu_addr, i_cpu_dat, we=i_cpu_we, cs=1; next state DONE.
REQ-021 In GRANT with i_vga_cs=1 (protocol violation), VGA SHALL win, no CPU RAM access SHALL occur, and the next state SHALL be IDLE with no ack (retry).
REQ-022 In DONE, o_cpu_ack SHALL be 1 for exactly one cycle; on reads, o_cpu_dat SHALL be loaded from i_ram_dat; on writes, o_cpu_dat SHALL hold its value; next state IDLE.
REQ-023 Minimum CPU latency SHALL be 2 cycles from request acceptance (IDLE cycle) to ack.
REQ-024 i_cpu_cs still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-025 i_cpu_cs dropped in GRANT SHALL NOT abort; access and ack SHALL complete.
REQ-026 When neither side drives, o_ram_cs=0, o_ram_we=0, o_ram_addr=0, o_ram_dat=0.

Reset
REQ-027 i_reset_n=0 SHALL immediately force state IDLE, o_cpu_ack=0, o_cpu_dat=0, stats counter 0, regardless of any operation in progress.
REQ-028 After reset deassertion, a pending i_cpu_cs SHALL be serviced as a fresh request.

Configuration
REQ-029 Macro VGARAM_ARB_STATS_EN defined SHALL add output o_stall_cnt (16 bit) and input i_stats_clr (1 bit).
REQ-030 With the macro, o_stall_cnt SHALL increment every cycle in IDLE with i_cpu_cs=1 and i_vga_access=1, saturating at 0xFFFF; i_stats_clr=1 SHALL zero it, with clear taking precedence over increment.
REQ-031 Without the macro, those ports and the counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-032 CPU read of 0x1234, RAM holding 0x5A, VGA idle -> ram cs in cycle 1, o_cpu_ack=1 and o_cpu_dat=0x5A in cycle 2.
REQ-033 CPU write of 0xA5 to 0x2000 -> one RAM cycle with we=1, dat=0xA5; ack 1 cycle later; o_cpu_dat unchanged.
REQ-034 Periodic VGA traffic (access at x%8=5, cs at 6,7) plus a continuous CPU read -> no cycle with both VGA and CPU on the RAM; CPU granted only in VGA-free slots.
REQ-035 Force i_vga_cs=1 during GRANT -> RAM shows VGA address, no ack that cycle, CPU retried and acked later with correct data.
REQ-036 Assert i_reset_n=0 during GRANT -> outputs 0 and state IDLE immediately; after release, the held request completes normally.
REQ-037 With VGARAM_ARB_STATS_EN, CPU blocked for 10 cycles -> o_stall_cnt=10; i_stats_clr -> 0; preloaded 0xFFFF plus blocking -> stays 0xFFFF.

Source files
------------

// File: rtl/vgaram_arbiter_if.sv
// vgaram_arbiter_if: VGA, CPU and RAM bus bundle for the VGA/CPU RAM arbiter.
// Stats ports exist only when VGARAM_ARB_STATS_EN is defined.
interface vgaram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] i_vga_addr;
    logic              i_vga_cs;
    logic              i_vga_access;
    logic [DATA_W-1:0] o_vga_dat;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_dat;
    logic              i_cpu_cs;
    logic              i_cpu_we;
    logic [DATA_W-1:0] o_cpu_dat;
    logic              o_cpu_ack;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_dat;
    logic              o_ram_cs;
    logic              o_ram_we;
    logic [DATA_W-1:0] i_ram_dat;
`ifdef VGARAM_ARB_STATS_EN
    logic [15:0]       o_stall_cnt;
    logic              i_stats_clr;
`endif

    modport master (
        output i_vga_addr, i_vga_cs, i_vga_access, i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we, i_ram_dat,
`ifdef VGARAM_ARB_STATS_EN
        output i_stats_clr,
        input  o_stall_cnt,
`endif
        input  o_vga_dat, o_cpu_dat, o_cpu_ack, o_ram_addr, o_ram_dat, o_ram_cs, o_ram_we
    );

    modport slave (
        input  i_vga_addr, i_vga_cs, i_vga_access, i_cpu_addr, i_cpu_dat, i_cpu_cs, i_cpu_we, i_ram_dat,
`ifdef VGARAM_ARB_STATS_EN
        input  i_stats_clr,
        output o_stall_cnt,
`endif
        output o_vga_dat, o_cpu_dat, o_cpu_ack, o_ram_addr, o_ram_dat, o_ram_cs, o_ram_we
    );
endinterface

// File: rtl/vgaram_arbiter.sv
// vgaram_arbiter: shares a synchronous RAM between a VGA fetcher (absolute priority) and a CPU.
// Define VGARAM_ARB_STATS_EN to add the saturating CPU stall counter.
module vgaram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input logic           i_clk,
    input logic           i_reset_n,
    vgaram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [DATA_W-1:0] cpu_dat_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            cpu_dat_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == GRANT) we_q <= bus.i_cpu_we;
            if (state_q == DONE && !we_q) cpu_dat_q <= bus.i_ram_dat;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.o_ram_addr = '0;
        bus.o_ram_dat  = '0;
        bus.o_ram_cs   = 1'b0;
        bus.o_ram_we   = 1'b0;
        case (state_q)
            IDLE:    state_d = (bus.i_cpu_cs && !bus.i_vga_access) ? GRANT : IDLE;
            GRANT:   state_d = bus.i_vga_cs ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (bus.i_vga_cs) begin
            bus.o_ram_addr = bus.i_vga_addr;
            bus.o_ram_cs   = 1'b1;
        end else if (state_q == GRANT) begin
            bus.o_ram_addr = bus.i_cpu_addr;
            bus.o_ram_dat  = bus.i_cpu_dat;
            bus.o_ram_cs   = 1'b1;
            bus.o_ram_we   = bus.i_cpu_we;
        end
    end

    // Read data is only valid in DONE, so it bypasses the register that cycle and is held afterwards.
    assign bus.o_cpu_ack = state_q == DONE;
    assign bus.o_cpu_dat = (state_q == DONE && !we_q) ? bus.i_ram_dat : cpu_dat_q;
    assign bus.o_vga_dat = bus.i_ram_dat;

`ifdef VGARAM_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) stall_q <= '0;
        else if (bus.i_stats_clr) stall_q <= '0;
        else if (state_q == IDLE && bus.i_cpu_cs && bus.i_vga_access && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end

    assign bus.o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_vgaram_arbiter.sv
// tb_vgaram_arbiter: table vectors, corner sequences and random traffic against a phase-based model.
// Stall counter checks run when VGARAM_ARB_STATS_EN is defined.
module tb_vgaram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vgaram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();
    vgaram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));

    logic [7:0] ram [65536];
    logic [7:0] gold [65536];
    logic [7:0] rd_q = 8'h00;
    assign bus.i_ram_dat = rd_q;

    int total = 0;
    int bad = 0;
    int ph = 0;
    int mst = 0;
    int acks = 0;
    logic mwe = 1'b0;
    logic [15:0] maddr = 16'h0;
    logic [7:0] mcd = 8'h00;
    logic p_cs = 1'b0;
    logic p_we = 1'b0;
    logic [15:0] p_addr = 16'h0;
    logic [7:0] p_dat = 8'h00;

    typedef struct {
        logic cs, we; logic [15:0] ca; logic [7:0] cd;
        logic vcs, vacc; logic [15:0] va;
        logic e_cs, e_we; logic [15:0] e_addr; logic [7:0] e_dat; logic e_ack; logic [7:0] e_cd;
    } vec_t;
    vec_t tbl [9];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    // Model: phase 0 = waiting, 1 = CPU owns the RAM this cycle, 2 = completion cycle.
    task automatic model_check();
        logic vcs;
        logic [31:0] e_addr;
        vcs = bus.i_vga_cs;
        if (!rst_n) begin ph = 0; mcd = 8'h00; mst = 0; end
        e_addr = vcs ? {16'h0, bus.i_vga_addr} : (ph == 1) ? {16'h0, bus.i_cpu_addr} : 32'h0;
        chk("ram_cs", bus.o_ram_cs, vcs || ph == 1);
        chk("ram_we", bus.o_ram_we, !vcs && ph == 1 && bus.i_cpu_we);
        chk("ram_addr", bus.o_ram_addr, e_addr);
        chk("ram_dat", bus.o_ram_dat, (!vcs && ph == 1) ? bus.i_cpu_dat : 8'h00);
        chk("cpu_ack", bus.o_cpu_ack, ph == 2);
        chk("cpu_dat", bus.o_cpu_dat, (ph == 2 && !mwe) ? gold[maddr] : mcd);
        chk("vga_dat", bus.o_vga_dat, rd_q);
`ifdef VGARAM_ARB_STATS_EN
        chk("stall_cnt", bus.o_stall_cnt, mst);
`endif
        if (rst_n) begin
`ifdef VGARAM_ARB_STATS_EN
            if (bus.i_stats_clr) mst = 0;
            else if (ph == 0 && bus.i_cpu_cs && bus.i_vga_access && mst < 65535) mst++;
`endif
            if (ph == 0) ph = (bus.i_cpu_cs && !bus.i_vga_access) ? 1 : 0;
            else if (ph == 1) begin
                if (vcs) ph = 0;
                else begin
                    mwe = bus.i_cpu_we;
                    maddr = bus.i_cpu_addr;
                    if (mwe) gold[maddr] = bus.i_cpu_dat;
                    ph = 2;
                end
            end else begin
                if (!mwe) mcd = gold[maddr];
                acks++;
                ph = 0;
            end
        end
    endtask

    task automatic step(input logic rn, cs, we, input logic [15:0] ca, input logic [7:0] cd,
                        input logic vcs, vacc, input logic [15:0] va, input logic clr);
        @(posedge clk);
        #1;
        if (p_cs) begin
            rd_q = ram[p_addr];
            if (p_we) ram[p_addr] = p_dat;
        end
        rst_n = rn;
        bus.i_cpu_cs = cs;
        bus.i_cpu_we = we;
        bus.i_cpu_addr = ca;
        bus.i_cpu_dat = cd;
        bus.i_vga_cs = vcs;
        bus.i_vga_access = vacc;
        bus.i_vga_addr = va;
`ifdef VGARAM_ARB_STATS_EN
        bus.i_stats_clr = clr;
`else
        if (clr) p_dat = p_dat;
`endif
        @(negedge clk);
        model_check();
        p_cs = bus.o_ram_cs;
        p_we = bus.o_ram_we;
        p_addr = bus.o_ram_addr;
        p_dat = bus.o_ram_dat;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic active, we;
        logic [15:0] ca;
        logic [7:0] cd;
        int a0, got;
        for (int a = 0; a < 65536; a++) begin
            ram[a] = 8'(a) ^ 8'h3C;
            gold[a] = 8'(a) ^ 8'h3C;
        end
        ram[16'h1234] = 8'h5A;
        gold[16'h1234] = 8'h5A;
        bus.i_cpu_cs = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = 0; bus.i_cpu_dat = 0;
        bus.i_vga_cs = 0; bus.i_vga_access = 0; bus.i_vga_addr = 0;
`ifdef VGARAM_ARB_STATS_EN
        bus.i_stats_clr = 0;
`endif
        tbl[0] = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 8'h00};
        tbl[1] = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'hBEEF, 1, 0, 16'hBEEF, 8'h00, 0, 8'h00};
        tbl[2] = '{1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 8'h00};
        tbl[3] = '{1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 1, 0, 16'h1234, 8'h00, 0, 8'h00};
        tbl[4] = '{1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1, 8'h5A};
        tbl[5] = '{1, 1, 16'h2000, 8'hA5, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 8'h5A};
        tbl[6] = '{1, 1, 16'h2000, 8'hA5, 0, 0, 16'h0000, 1, 1, 16'h2000, 8'hA5, 0, 8'h5A};
        tbl[7] = '{1, 1, 16'h2000, 8'hA5, 0, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 1, 8'h5A};
        tbl[8] = '{0, 0, 16'h0000, 8'h00, 0, 1, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 8'h5A};

        for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0042, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, tbl[i].cs, tbl[i].we, tbl[i].ca, tbl[i].cd, tbl[i].vcs, tbl[i].vacc, tbl[i].va, 0);
            chk($sformatf("tbl%0d_ram_cs", i), bus.o_ram_cs, tbl[i].e_cs);
            chk($sformatf("tbl%0d_ram_we", i), bus.o_ram_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_ram_addr", i), bus.o_ram_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_ram_dat", i), bus.o_ram_dat, tbl[i].e_dat);
            chk($sformatf("tbl%0d_ack", i), bus.o_cpu_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_cpu_dat", i), bus.o_cpu_dat, tbl[i].e_cd);
        end

        // VGA steals the RAM during GRANT: no ack, request retried
        idle(2);
        step(1, 1, 0, 16'h0040, 0, 0, 0, 0, 0);
        step(1, 1, 0, 16'h0040, 0, 1, 0, 16'h0777, 0);
        chk("steal_addr", bus.o_ram_addr, 16'h0777);
        chk("steal_we", bus.o_ram_we, 0);
        chk("steal_ack", bus.o_cpu_ack, 0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1, 1, 0, 16'h0040, 0, 0, 0, 0, 0);
            got = int'(bus.o_cpu_ack);
        end
        chk("steal_retry_acked", got, 1);
        chk("steal_retry_dat", bus.o_cpu_dat, 8'h7C);

        // Reset during GRANT, then the held request completes
        idle(1);
        step(1, 1, 0, 16'h0101, 0, 0, 0, 0, 0);
        step(0, 1, 0, 16'h0101, 0, 0, 0, 0, 0);
        chk("rst_ack", bus.o_cpu_ack, 0);
        chk("rst_cpu_dat", bus.o_cpu_dat, 8'h00);
        chk("rst_ram_cs", bus.o_ram_cs, 0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1, 1, 0, 16'h0101, 0, 0, 0, 0, 0);
            got = int'(bus.o_cpu_ack);
        end
        chk("rst_retry_acked", got, 1);
        chk("rst_retry_dat", bus.o_cpu_dat, 8'h3D);

        // Periodic VGA slots with a continuous CPU read stream
        idle(1);
        a0 = acks;
        ca = 16'h0300;
        for (int x = 0; x < 96; x++) begin
            step(1, 1, 0, ca, 0, (x % 8) inside {6, 7}, (x % 8) == 5, 16'h8000 + 16'(x), 0);
            if (bus.o_cpu_ack) ca = 16'h0300 + 16'($urandom_range(0, 15));
        end
        chk("periodic_progress", acks - a0 > 4, 1);

        // Random traffic
        idle(2);
        active = 0; we = 0; ca = 0; cd = 0;
        for (int i = 0; i < 800; i++) begin
            if (!active && $urandom_range(0, 1) == 1) begin
                active = 1;
                we = 1'($urandom_range(0, 1));
                ca = 16'h0100 + 16'($urandom_range(0, 15));
                cd = 8'($urandom);
            end
            step(1, active && $urandom_range(0, 15) != 0, we, ca, cd,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 16'($urandom), 0);
            if (bus.o_cpu_ack) active = 0;
        end

`ifdef VGARAM_ARB_STATS_EN
        idle(3);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 16'h0010, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_ten", bus.o_stall_cnt, 16'd10);
        step(1, 1, 0, 16'h0010, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_clr", bus.o_stall_cnt, 16'd0);
        for (int i = 0; i < 65540; i++) step(1, 1, 0, 16'h0010, 0, 0, 1, 0, 0);
        chk("stall_sat", bus.o_stall_cnt, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
